// File: rtl/tile_result_collector.sv
// Merges SNN/CNN per-tile results into a show-ahead FIFO tagged with source and tile index.
// Optional per-source accepted-result counters are enabled by defining TILE_RESULT_STATS_EN.
module tile_result_collector #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int TILES_PER_FRAME = 1200
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iClear,
    input  logic [DATA_WIDTH-1:0] iSnnResult,
    input  logic                  iSnnValid,
    input  logic [DATA_WIDTH-1:0] iCnnResult,
    input  logic                  iCnnValid,
    input  logic                  iReady,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oSrcCnn,
    output logic [10:0]           oTileIdx,
    output logic                  oValid,
    output logic                  oFrameDone,
`ifdef TILE_RESULT_STATS_EN
    output logic [10:0]           oSnnCount,
    output logic [10:0]           oCnnCount,
`endif
    output logic                  oOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  src;
        logic [10:0]           idx;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           count;
    logic                  pend_vld;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [10:0]           tile_idx, tile_next;
    logic                  overflow, frame_done;

    logic                  wr_req, wr_src, pend_load, drop_new;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  valid, full, pop, push, wr_drop;
    entry_t                head, wr_entry;

    // A held SNN result always wins; any strobe arriving alongside it is lost.
    always_comb begin
        wr_req    = 1'b0;
        wr_src    = 1'b0;
        wr_data   = '0;
        pend_load = 1'b0;
        drop_new  = 1'b0;
        if (pend_vld) begin
            wr_req   = 1'b1;
            wr_data  = pend_data;
            drop_new = iCnnValid | iSnnValid;
        end else if (iCnnValid) begin
            wr_req    = 1'b1;
            wr_src    = 1'b1;
            wr_data   = iCnnResult;
            pend_load = iSnnValid;
        end else if (iSnnValid) begin
            wr_req  = 1'b1;
            wr_data = iSnnResult;
        end
    end

    assign valid     = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = valid & iReady;
    assign push      = wr_req & (~full | pop);
    assign wr_drop   = wr_req & full & ~pop;
    assign tile_next = (tile_idx == 11'(TILES_PER_FRAME-1)) ? 11'd0 : tile_idx + 11'd1;
    assign wr_entry  = '{src: wr_src, idx: tile_idx, data: wr_data};
    assign head      = mem[rd_ptr];

    assign oValid     = valid;
    assign oData      = valid ? head.data : '0;
    assign oSrcCnn    = valid ? head.src  : 1'b0;
    assign oTileIdx   = valid ? head.idx  : 11'd0;
    assign oFrameDone = frame_done;
    assign oOverflow  = overflow;

    always_ff @(posedge iClk) begin
        if (push && !iClear)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            tile_idx   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else if (iClear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            tile_idx   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (pend_load) begin
                pend_vld  <= 1'b1;
                pend_data <= iSnnResult;
            end else begin
                pend_vld  <= 1'b0;
            end
            // Index advances even on a full-FIFO drop so the gap is visible downstream.
            if (wr_req) tile_idx <= tile_next;
            if (wr_drop || drop_new) overflow <= 1'b1;
            frame_done <= pop && (head.idx == 11'(TILES_PER_FRAME-1));
        end
    end

`ifdef TILE_RESULT_STATS_EN
    logic [10:0] snn_cnt, cnn_cnt;
    logic        acc_snn, acc_cnn;

    assign acc_snn   = push & ~wr_src;
    assign acc_cnn   = push &  wr_src;
    assign oSnnCount = snn_cnt;
    assign oCnnCount = cnn_cnt;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            snn_cnt <= '0;
            cnn_cnt <= '0;
        end else if (iClear) begin
            snn_cnt <= '0;
            cnn_cnt <= '0;
        end else if (frame_done) begin
            snn_cnt <= 11'(acc_snn);
            cnn_cnt <= 11'(acc_cnn);
        end else begin
            snn_cnt <= snn_cnt + 11'(acc_snn);
            cnn_cnt <= cnn_cnt + 11'(acc_cnn);
        end
    end
`endif

endmodule

// File: tb/tb_tile_result_collector.sv
// Scoreboard bench for tile_result_collector: stimulus pushes expected entries, a monitor pops on handshake.
module tb_tile_result_collector;

    logic       iClk = 1'b0, iRst = 1'b0, iClear = 1'b0;
    logic       iSnnValid = 1'b0, iCnnValid = 1'b0, iReady = 1'b0;
    logic [7:0] iSnnResult = '0, iCnnResult = '0;
    logic [7:0] oData;
    logic       oSrcCnn, oValid, oFrameDone, oOverflow;
    logic [10:0] oTileIdx;
`ifdef TILE_RESULT_STATS_EN
    logic [10:0] oSnnCount, oCnnCount;
`endif

    tile_result_collector #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .TILES_PER_FRAME(1200)) dut (
        .iClk(iClk), .iRst(iRst), .iClear(iClear),
        .iSnnResult(iSnnResult), .iSnnValid(iSnnValid),
        .iCnnResult(iCnnResult), .iCnnValid(iCnnValid),
        .iReady(iReady),
        .oData(oData), .oSrcCnn(oSrcCnn), .oTileIdx(oTileIdx), .oValid(oValid),
        .oFrameDone(oFrameDone),
`ifdef TILE_RESULT_STATS_EN
        .oSnnCount(oSnnCount), .oCnnCount(oCnnCount),
`endif
        .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic       src;
        logic [10:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;
    logic pop_last_prev = 1'b0;
    logic fd_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every handshake.
    always @(negedge iClk) begin
        exp_t e;
        if (iRst) begin
            if (oFrameDone || pop_last_prev) check("frame_done_pulse", 32'(oFrameDone), 32'(pop_last_prev));
            if (oFrameDone) fd_cnt++;
`ifdef TILE_RESULT_STATS_EN
            if (oFrameDone) check("stats_sum", 32'(oSnnCount) + 32'(oCnnCount), 32'd1200);
            if (fd_prev)    check("stats_cleared", 32'(oSnnCount) + 32'(oCnnCount), 32'd0);
`endif
            fd_prev       = oFrameDone;
            pop_last_prev = 1'b0;
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry actual idx=%0d data=0x%0h required none", oTileIdx, oData);
                end else begin
                    e = exp_q.pop_front();
                    check("head_data", 32'(oData), 32'(e.data));
                    check("head_src", 32'(oSrcCnn), 32'(e.src));
                    check("head_idx", 32'(oTileIdx), 32'(e.idx));
                end
                if (oTileIdx == 11'd1199) pop_last_prev = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic src, input int idx, input logic [7:0] data);
        exp_t e;
        e = '{src: src, idx: 11'(idx), data: data};
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic cv, input logic [7:0] cd, input logic sv, input logic [7:0] sd);
        @(posedge iClk); #1;
        iCnnValid = cv; iCnnResult = cd;
        iSnnValid = sv; iSnnResult = sd;
    endtask

    task automatic idle();
        @(posedge iClk); #1;
        iCnnValid = 1'b0;
        iSnnValid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b0;
        exp_q.delete();
        @(negedge iClk);
        iRst = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || oValid) && n < budget) begin
            @(posedge iClk); #2;
            n++;
        end
        check(name, 32'(exp_q.size()) + 32'(oValid), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(oValid), 0);
        check("rst_frame_done", 32'(oFrameDone), 0);
        check("rst_overflow", 32'(oOverflow), 0);
        check("rst_data", 32'(oData), 0);
        check("rst_src", 32'(oSrcCnn), 0);
        check("rst_idx", 32'(oTileIdx), 0);
        @(negedge iClk);
        iRst = 1'b1;

        // Single CNN result: visible the cycle after the strobe, gone the cycle after that.
        iReady = 1'b1;
        push_exp(1'b1, 0, 8'h5A);
        issue(1'b1, 8'h5A, 1'b0, 8'h00);
        idle();
        @(negedge iClk);
        check("lat_valid", 32'(oValid), 1);
        check("lat_data", 32'(oData), 32'h5A);
        @(negedge iClk);
        check("lat_empty", 32'(oValid), 0);

        // Simultaneous strobes: CNN at k, SNN at k+1.
        do_reset();
        iReady = 1'b1;
        push_exp(1'b1, 0, 8'h11);
        push_exp(1'b0, 1, 8'h22);
        issue(1'b1, 8'h11, 1'b1, 8'h22);
        idle();
        drain("simul_drain", 10);

        // Backpressure: 16 held, 17th dropped but consumes idx 16.
        do_reset();
        iReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) push_exp(1'b0, i, 8'(8'h80 + i));
            issue(1'b0, 8'h00, 1'b1, 8'(8'h80 + i));
        end
        idle();
        @(negedge iClk);
        check("ovf_set", 32'(oOverflow), 1);
        check("full_valid", 32'(oValid), 1);
        repeat (3) @(negedge iClk);
        check("hold_data", 32'(oData), 32'h80);
        check("hold_idx", 32'(oTileIdx), 0);
        @(posedge iClk); #1;
        iReady = 1'b1;
        drain("ovf_drain", 40);
        push_exp(1'b0, 17, 8'h77);
        issue(1'b0, 8'h00, 1'b1, 8'h77);
        idle();
        drain("gap_drain", 10);

        // Asynchronous reset between edges discards queued entries at once.
        do_reset();
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
        idle();
        @(negedge iClk);
        check("pre_rst_valid", 32'(oValid), 1);
        #2 iRst = 1'b0;
        #1;
        check("async_rst_valid", 32'(oValid), 0);
        check("async_rst_data", 32'(oData), 0);
        #1 iRst = 1'b1;
        @(negedge iClk);
        check("post_rst_valid", 32'(oValid), 0);
        iReady = 1'b1;
        push_exp(1'b1, 0, 8'h99);
        issue(1'b1, 8'h99, 1'b0, 8'h00);
        idle();
        drain("post_rst_drain", 10);

        // Clear with overflow set and a strobe in the clear cycle.
        iReady = 1'b0;
        for (int i = 0; i < 17; i++) issue(1'b0, 8'h00, 1'b1, 8'(i));
        idle();
        @(negedge iClk);
        check("clr_pre_ovf", 32'(oOverflow), 1);
        @(posedge iClk); #1;
        iClear = 1'b1;
        iCnnValid = 1'b1; iCnnResult = 8'hAB;
        @(posedge iClk); #1;
        iClear = 1'b0;
        iCnnValid = 1'b0;
        @(negedge iClk);
        check("clr_valid", 32'(oValid), 0);
        check("clr_ovf", 32'(oOverflow), 0);
        iReady = 1'b1;
        push_exp(1'b1, 0, 8'h3C);
        issue(1'b1, 8'h3C, 1'b0, 8'h00);
        idle();
        drain("clr_drain", 10);

        // Full frame: pulse after idx 1199, then wrap to idx 0.
        do_reset();
        iReady = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            push_exp(i[0], i, 8'(i));
            issue(i[0], 8'(i), !i[0], 8'(i));
        end
        idle();
        begin
            int n = 0;
            while (fd_cnt < 1 && n < 20) begin
                @(posedge iClk); #2;
                n++;
            end
            check("frame_done_seen", 32'(fd_cnt), 1);
        end
        push_exp(1'b1, 0, 8'hEE);
        issue(1'b1, 8'hEE, 1'b0, 8'h00);
        idle();
        drain("wrap_drain", 10);
        check("frame_done_count", 32'(fd_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
